// File: rtl/seg_bus_pkg.sv
// Shared 7-segment constants (active-low, bit6=a .. bit0=g) for the display
// encoder and the capture path.
package seg_bus_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg2bin.sv
// Combinational 7-segment to BCD decoder; blank and unknown patterns both
// yield CODE_BLANK, only unknown ones flag illegal.
module seg2bin
    import seg_bus_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       blank,
    output logic       illegal
);

    always_comb begin
        code    = CODE_BLANK;
        blank   = 1'b0;
        illegal = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: blank = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_bus_capture.sv
// Captures a multiplexed active-low 4-digit 7-segment bus back into BCD,
// accepting each digit only after it has been stable for STABLE_CYCLES.
module seg_bus_capture
    import seg_bus_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an_in,
    input  logic [7:0]  seg_in,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    logic [10:0]                 sample;
    logic [10:0]                 prev_reg;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic                        captured_reg, captured_next;
    logic [NUM_DIGITS-1:0]       done_reg, done_next, done_merged;
    logic [NUM_DIGITS-1:0]       sel;
    logic                        legal, mismatch, capture, frame_done;

    logic [NUM_DIGITS-1:0][3:0]  slot_code_reg, frame_code;
    logic [NUM_DIGITS-1:0]       slot_err_reg, frame_errs;
    logic [NUM_DIGITS-1:0][3:0]  bcd_reg;
    logic                        frame_valid_reg, frame_err_reg;

    logic [3:0]                  dec_code, seg_code;
    logic                        dec_blank, dec_illegal;

    seg2bin u_seg2bin (
        .seg     (seg_in[6:0]),
        .code    (dec_code),
        .blank   (dec_blank),
        .illegal (dec_illegal)
    );

    assign seg_code = dec_blank ? CODE_BLANK : dec_code;
    assign sample   = {an_in, seg_in[6:0]};
    assign sel      = ~an_in;
    assign legal    = ($countones(sel) == 1);
    assign mismatch = (sample != prev_reg);

    // A broken run (new pair or illegal selection) re-arms capture; the
    // capture test uses the re-armed flag so STABLE_CYCLES=1 works.
    always_comb begin
        cnt_next      = cnt_reg;
        captured_next = captured_reg;
        capture       = 1'b0;
        if (!legal) begin
            cnt_next      = '0;
            captured_next = 1'b0;
        end else begin
            if (mismatch) begin
                cnt_next      = CNT_W'(1);
                captured_next = 1'b0;
            end else if (cnt_reg != STABLE_CNT) begin
                cnt_next = cnt_reg + 1'b1;
            end
            if ((cnt_next == STABLE_CNT) && !captured_next) begin
                capture       = 1'b1;
                captured_next = 1'b1;
            end
        end
    end

    // Slot contents merged with the digit captured this cycle, so the frame
    // that completes on this edge already includes it.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign frame_code[gi] = (capture && sel[gi]) ? seg_code : slot_code_reg[gi];
            assign frame_errs[gi] = (capture && sel[gi]) ? dec_illegal : slot_err_reg[gi];
        end
    endgenerate

    assign done_merged = capture ? (done_reg | sel) : done_reg;
    assign frame_done  = capture && (&done_merged);
    assign done_next   = frame_done ? '0 : done_merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg        <= '0;
            cnt_reg         <= '0;
            captured_reg    <= 1'b0;
            done_reg        <= '0;
            slot_code_reg   <= '0;
            slot_err_reg    <= '0;
            bcd_reg         <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            prev_reg        <= sample;
            cnt_reg         <= cnt_next;
            captured_reg    <= captured_next;
            done_reg        <= done_next;
            slot_code_reg   <= frame_code;
            slot_err_reg    <= frame_errs;
            frame_valid_reg <= frame_done;
            if (frame_done) begin
                bcd_reg       <= frame_code;
                frame_err_reg <= |frame_errs;
            end
        end
    end

    assign bcd_out     = bcd_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_seg_bus_capture.sv
// Directed scoreboard bench for seg_bus_capture: stimulus queues expected
// frames, a negedge monitor pops and compares on every frame_valid.
module tb_seg_bus_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_in;
    logic [7:0]  seg_in;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int frame_edge = -1;
    int frames_seen = 0;
    int e0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_item;

    seg_bus_capture #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hold(4'b1111, 8'hFF, n);
    endtask

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            frames_seen++;
            frame_edge = edge_cnt;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got bcd=%h err=%b expected no frame", bcd_out, frame_err);
            end else begin
                exp_item = exp_q.pop_front();
                check("frame_bcd", {16'h0, bcd_out}, {16'h0, exp_item[16:1]});
                check("frame_err", {31'h0, frame_err}, {31'h0, exp_item[0]});
            end
        end
    end

    initial begin
        // Reset with bus activity
        rst = 1'b1;
        hold(4'b1110, 8'h84, 1);
        hold(4'b0111, 8'h01, 1);
        check("rst_bcd", {16'h0, bcd_out}, 32'h0);
        check("rst_valid", {31'h0, frame_valid}, 32'h0);
        check("rst_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("idle_no_strobe", {31'h0, frame_valid}, 32'h0);
        end

        // Clean scan: 9,3,0,7 -> 7039 on the 16th edge
        e0 = edge_cnt;
        exp_q.push_back({16'h7039, 1'b0});
        hold(4'b1110, 8'h84, 4);
        hold(4'b1101, 8'h86, 4);
        hold(4'b1011, 8'h01, 4);
        hold(4'b0111, 8'h8F, 4);
        idle(2);
        check("scan_latency", frame_edge, e0 + 16);
        check("hold_bcd", {16'h0, bcd_out}, 32'h7039);
        check("hold_err", {31'h0, frame_err}, 32'h0);

        // Glitch rejection: 3-cycle holds, then 5-cycle holds
        hold(4'b1110, 8'h4F, 3);
        hold(4'b1101, 8'h12, 3);
        hold(4'b1011, 8'h24, 3);
        hold(4'b0111, 8'h20, 3);
        idle(3);
        exp_q.push_back({16'h6521, 1'b0});
        hold(4'b1110, 8'h4F, 5);
        hold(4'b1101, 8'h12, 5);
        hold(4'b1011, 8'h24, 5);
        hold(4'b0111, 8'h20, 5);
        idle(3);

        // Illegal and blank patterns, dp ignored
        exp_q.push_back({16'h0FF0, 1'b1});
        hold(4'b1110, 8'h81, 4);
        hold(4'b1101, 8'hFE, 4);
        hold(4'b1011, 8'hFF, 4);
        hold(4'b0111, 8'h01, 4);
        idle(3);

        // Illegal selection between captures
        exp_q.push_back({16'h9384, 1'b0});
        hold(4'b1110, 8'h4C, 4);
        hold(4'b1101, 8'h00, 4);
        hold(4'b1100, 8'h4F, 10);
        hold(4'b1111, 8'h4F, 10);
        hold(4'b1011, 8'h06, 4);
        hold(4'b0111, 8'h04, 4);
        idle(3);

        // Mid-frame reset discards partial frame
        hold(4'b1110, 8'h24, 4);
        hold(4'b1101, 8'h20, 4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_bcd", {16'h0, bcd_out}, 32'h0);
        check("midrst_err", {31'h0, frame_err}, 32'h0);
        hold(4'b1011, 8'h0F, 4);
        hold(4'b0111, 8'h00, 4);
        idle(3);
        exp_q.push_back({16'h8721, 1'b0});
        hold(4'b1110, 8'h4F, 4);
        hold(4'b1101, 8'h12, 4);
        idle(3);

        check("frames_pending", exp_q.size(), 32'd0);
        check("frame_count", frames_seen, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
